// File: rtl/dmem_arbiter.sv
// Data memory arbiter between the pipeline MEM stage (core) and a debug/loader
// port. The core has priority. A waiting debug request is forced through after
// STARVE_LIMIT cycles of core traffic, and the MEM stage is stalled for that one
// cycle. Debug accesses are always full words.
module dmem_arbiter #(
  parameter int unsigned DM_ADDRESS   = 9,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // MEM-stage side
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_func3,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  core_stall,
  input  logic                  core_halted,
  // Debug request/response side
  input  logic                  dbg_req_valid,
  output logic                  dbg_req_ready,
  input  logic                  dbg_we,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_resp_valid,
  input  logic                  dbg_resp_ready,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  dbg_err,
  // Data memory side
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned    CntW   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);
  localparam logic [2:0]     Func3Word = 3'b010;

  typedef enum logic [1:0] {
    StIdle,
    StPend,
    StResp
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [DM_ADDRESS-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic core_req;
  logic misaligned;
  logic pend_grant;
  logic dbg_grant;

  assign core_req   = core_rd | core_wr;
  assign misaligned = |addr_q[1:0];

  // Debug owns the memory this cycle. Misaligned requests never touch memory,
  // and reset drops the pending request so no access leaks out in that cycle.
  assign pend_grant = (state_q == StPend) && !misaligned &&
                      (!core_req || core_halted || (cnt_q == CntMax));
  assign dbg_grant  = pend_grant && !reset;

  // Next-state logic: accept, wait for grant or starvation, then hold response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (dbg_req_valid) begin
          we_d    = dbg_we;
          addr_d  = dbg_addr;
          wdata_d = dbg_wdata;
          state_d = StPend;
        end
      end
      StPend: begin
        if (misaligned) begin
          rdata_d = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = StResp;
        end else if (pend_grant) begin
          rdata_d = we_q ? '0 : mem_rdata;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = StResp;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        if (dbg_resp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and holding registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory bus mux: core pass-through unless debug holds the grant.
  always_comb begin
    mem_rd     = core_rd;
    mem_wr     = core_wr && !reset;
    mem_addr   = core_addr;
    mem_wdata  = core_wdata;
    mem_func3  = core_func3;
    core_rdata = mem_rdata;
    core_stall = 1'b0;
    if (dbg_grant) begin
      mem_rd     = !we_q;
      mem_wr     = we_q;
      mem_addr   = addr_q;
      mem_wdata  = wdata_q;
      mem_func3  = Func3Word;
      core_rdata = '0;
      core_stall = core_req;
    end
  end

  assign dbg_req_ready  = (state_q == StIdle) && !reset;
  assign dbg_resp_valid = (state_q == StResp) && !reset;
  assign dbg_rdata      = rdata_q;
  assign dbg_err        = err_q;

endmodule
